// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one outstanding imem request,
// hazard-unit stall/flush, branch redirect and a one-entry buffer for acks that land during a stall.
module if_fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]   buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0]   buf_pc4_q, buf_pc4_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   pc4_q, pc4_d;
  logic                req_c;
  logic                deliver_c;

  // A full buffer blocks new requests, so at most one response is ever pending.
  assign req_c     = (state_q == S_REQ) & ~buf_valid_q & ~flush & ~reset;
  assign deliver_c = (state_q == S_WAIT) & imem_ack & ~flush;

  assign imem_req       = req_c;
  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d = branch_target;
        end else if (req_c) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_REQ;
          if (flush) pc_d = branch_target;
        end else if (flush) begin
          pc_d    = branch_target;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The wrong-path response is still owed by memory; wait for it and throw it away.
        if (flush)    pc_d    = branch_target;
        if (imem_ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    if (flush) begin
      valid_d     = 1'b0;
      instr_d     = '0;
      buf_valid_d = 1'b0;
    end else if (stall) begin
      if (deliver_c) begin
        buf_valid_d = 1'b1;
        buf_instr_d = imem_rdata;
        buf_pc4_d   = req_pc_q + ADDR_W'(4);
      end
    end else if (buf_valid_q) begin
      valid_d     = 1'b1;
      instr_d     = buf_instr_q;
      pc4_d       = buf_pc4_q;
      buf_valid_d = 1'b0;
    end else if (deliver_c) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      pc4_d   = req_pc_q + ADDR_W'(4);
    end else begin
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: randomized stall/flush/latency/reset against a
// transaction-level model of the fetch stream and IF/ID deliveries.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, stall, flush, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due; bit live; bit stray;} mreq_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} ifid_t;

  mreq_t       mem_q[$];
  ifid_t       pend_q[$];
  ifid_t       exp_q[$];
  int          checks = 0, passed = 0, cyc = 0;
  int          p_stall = 0, p_flush = 0, lat_max = 1;
  bit          rst_next;
  logic [31:0] pc_m;

  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every new IF/ID presentation must match the head of the expected queue.
  bit          pv;
  logic [31:0] pi, pp;
  ifid_t       e;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0; pi = '0; pp = '0;
    end else begin
      if (if_id_valid && (!pv || if_id_instr != pi || if_id_pc_plus4 != pp)) begin
        if (exp_q.size() == 0) chk("unexpected_instr", 1'b0, if_id_pc_plus4, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("if_id_instr", if_id_instr == e.instr, if_id_instr, e.instr);
          chk("if_id_pc_plus4", if_id_pc_plus4 == e.pc4, if_id_pc_plus4, e.pc4);
        end
      end else if (!if_id_valid) begin
        chk("bubble_instr", if_id_instr == 32'h0, if_id_instr, 32'h0);
        chk("bubble_pc4_hold", if_id_pc_plus4 == pp, if_id_pc_plus4, pp);
      end
      if (exp_q.size() != 0) begin
        chk("missing_instr", 1'b0, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
      end
      pv = if_id_valid; pi = if_id_instr; pp = if_id_pc_plus4;
    end
  end

  task automatic step();
    bit s_reset, s_stall, s_flush, s_ack, s_req, busy, req_exp;
    logic [31:0] s_tgt, s_addr;
    mreq_t m;
    @(negedge clk);
    s_reset = reset; s_stall = stall; s_flush = flush; s_ack = imem_ack;
    s_tgt = branch_target; s_req = imem_req; s_addr = imem_addr;
    busy = 1'b0;
    foreach (mem_q[i]) if (!mem_q[i].stray) busy = 1'b1;
    req_exp = 1'b0;
    if (s_reset) begin
      chk("reset_req", !s_req, 32'(s_req), 32'h0);
      chk("reset_valid", !if_id_valid, 32'(if_id_valid), 32'h0);
      chk("reset_instr", if_id_instr == 32'h0, if_id_instr, 32'h0);
      chk("reset_pc4", if_id_pc_plus4 == 32'h0, if_id_pc_plus4, 32'h0);
    end else begin
      req_exp = !busy && pend_q.size() == 0 && !s_flush;
      chk("imem_req", s_req == req_exp, 32'(s_req), 32'(req_exp));
      if (s_req) chk("imem_addr", s_addr == pc_m, s_addr, pc_m);
    end
    @(posedge clk);
    cyc++;
    if (s_reset) begin
      pc_m = RST_PC;
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (s_ack && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (!m.stray && m.live && !s_flush)
          pend_q.push_back(ifid_t'{instr: code(m.addr), pc4: m.addr + 32'd4});
      end
      if (s_flush) foreach (mem_q[i]) mem_q[i].live = 1'b0;
      if (s_req)
        mem_q.push_back(mreq_t'{addr: s_addr, due: cyc + int'($urandom_range(1, lat_max)),
                                live: 1'b1, stray: 1'b0});
      if (s_flush) begin
        pc_m = s_tgt;
        pend_q.delete();
      end else begin
        if (req_exp) pc_m = pc_m + 32'd4;
        if (!s_stall && pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      end
    end
    #1;
    if (rst_next && !reset) foreach (mem_q[i]) mem_q[i].stray = 1'b1;
    if (!rst_next && reset && mem_q.size() > 0) mem_q[0].due = cyc + 1;
    reset = rst_next;
    imem_ack = 1'b0;
    imem_rdata = $urandom();
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      imem_ack = 1'b1;
      if (!mem_q[0].stray) imem_rdata = code(mem_q[0].addr);
    end
    stall = ($urandom_range(0, 99) < p_stall);
    flush = ($urandom_range(0, 99) < p_flush);
    branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; branch_target = '0; rst_next = 1'b1; pc_m = RST_PC;
    repeat (3) step();
    rst_next = 1'b0;
    lat_max = 1; repeat (40) step();
    lat_max = 3; p_stall = 30; repeat (300) step();
    lat_max = 4; p_stall = 25; p_flush = 15; repeat (1500) step();
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(5, 30)) step();
      rst_next = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      rst_next = 1'b0;
    end
    p_stall = 0; p_flush = 0;
    repeat (20) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
